// File: rtl/qspi_arb_pkg.sv
// Shared types and constants for the QSPI pad arbiter.
package qspi_arb_pkg;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_OWN_M0 = 2'd1,
        ST_OWN_M1 = 2'd2,
        ST_GUARD  = 2'd3
    } arb_state_t;

    // Current pad owner, encoded exactly as presented on owner_o
    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_M0   = 2'b01,
        OWN_M1   = 2'b10
    } arb_owner_t;

    // Pad levels while nobody owns the bus: flash deselected, lines released
    localparam logic       IDLE_SCLK = 1'b0;
    localparam logic       IDLE_CS_N = 1'b1;
    localparam logic [3:0] IDLE_DATA = 4'h0;
    localparam logic [3:0] IDLE_OEN  = 4'hF;

    // Winner selection from IDLE; prio_m1 forces m1 on a tie, otherwise
    // the master that did not own the bus last wins the tie.
    function automatic arb_state_t idle_pick(input logic m0_req,
                                             input logic m1_req,
                                             input logic prio_m1,
                                             input logic last_m1);
        arb_state_t pick;
        if (m0_req && m1_req) begin
            if (prio_m1 || !last_m1) begin
                pick = ST_OWN_M1;
            end else begin
                pick = ST_OWN_M0;
            end
        end else if (m0_req) begin
            pick = ST_OWN_M0;
        end else if (m1_req) begin
            pick = ST_OWN_M1;
        end else begin
            pick = ST_IDLE;
        end
        return pick;
    endfunction

endpackage

// File: rtl/qspi_arb_pad_mux.sv
// Combinational owner-to-pad steering. Only the owning master reaches the
// pads; with no owner the pads sit at deselected idle levels.
module qspi_arb_pad_mux
    import qspi_arb_pkg::*;
(
    input  arb_owner_t  owner,
    input  logic        m0_sclk,
    input  logic        m0_cs_n,
    input  logic [3:0]  m0_data_out,
    input  logic [3:0]  m0_oen,
    output logic [3:0]  m0_data_in,
    input  logic        m1_sclk,
    input  logic        m1_cs_n,
    input  logic [3:0]  m1_data_out,
    input  logic [3:0]  m1_oen,
    output logic [3:0]  m1_data_in,
    output logic        pad_sclk,
    output logic        pad_cs_n,
    output logic [3:0]  pad_data_out,
    output logic [3:0]  pad_oen,
    input  logic [3:0]  pad_data_in
);

    // Select pad drive and route pad input data to the owner only
    always_comb begin
        pad_sclk     = IDLE_SCLK;
        pad_cs_n     = IDLE_CS_N;
        pad_data_out = IDLE_DATA;
        pad_oen      = IDLE_OEN;
        m0_data_in   = 4'h0;
        m1_data_in   = 4'h0;
        case (owner)
            OWN_M0: begin
                pad_sclk     = m0_sclk;
                pad_cs_n     = m0_cs_n;
                pad_data_out = m0_data_out;
                pad_oen      = m0_oen;
                m0_data_in   = pad_data_in;
            end
            OWN_M1: begin
                pad_sclk     = m1_sclk;
                pad_cs_n     = m1_cs_n;
                pad_data_out = m1_data_out;
                pad_oen      = m1_oen;
                m1_data_in   = pad_data_in;
            end
            OWN_NONE: begin
                pad_sclk     = IDLE_SCLK;
                pad_cs_n     = IDLE_CS_N;
                pad_data_out = IDLE_DATA;
                pad_oen      = IDLE_OEN;
            end
            default: begin
                pad_sclk     = IDLE_SCLK;
                pad_cs_n     = IDLE_CS_N;
                pad_data_out = IDLE_DATA;
                pad_oen      = IDLE_OEN;
            end
        endcase
    end

endmodule

// File: rtl/qspi_bus_arbiter.sv
// Two-master QSPI pad arbiter. Ownership changes only when the owner has
// dropped its request with CS high; a guard interval with the flash
// deselected separates consecutive owners.
module qspi_bus_arbiter
    import qspi_arb_pkg::*;
#(
    parameter int GUARD_CYCLES = 4,
    parameter int GUARD_W      = 3
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        prio_m1_i,
    input  logic        m0_req_i,
    output logic        m0_gnt_o,
    input  logic        m0_sclk_i,
    input  logic        m0_cs_ni,
    input  logic [3:0]  m0_data_o_i,
    input  logic [3:0]  m0_oen_i,
    output logic [3:0]  m0_data_i_o,
    input  logic        m1_req_i,
    output logic        m1_gnt_o,
    input  logic        m1_sclk_i,
    input  logic        m1_cs_ni,
    input  logic [3:0]  m1_data_o_i,
    input  logic [3:0]  m1_oen_i,
    output logic [3:0]  m1_data_i_o,
    output logic        qspi_sclk_o,
    output logic        qspi_cs_no,
    output logic [3:0]  qspi_data_o,
    output logic [3:0]  qspi_data_oen,
    input  logic [3:0]  qspi_data_i,
    output logic        busy_o,
    output logic [1:0]  owner_o
);

    localparam bit               GUARD_EN   = (GUARD_CYCLES > 32'sd0);
    localparam logic [GUARD_W-1:0] GUARD_LOAD =
        GUARD_EN ? GUARD_W'(GUARD_CYCLES - 32'sd1) : {GUARD_W{1'b0}};
    localparam logic [GUARD_W-1:0] GUARD_ONE  = GUARD_W'(32'd1);
    localparam logic [GUARD_W-1:0] GUARD_ZERO = {GUARD_W{1'b0}};

    arb_state_t         state_r;
    arb_state_t         state_s;
    logic [GUARD_W-1:0] guard_r;
    logic [GUARD_W-1:0] guard_s;
    logic               last_m1_r;
    logic               last_m1_s;
    arb_owner_t         owner_r;
    logic               m0_gnt_r;
    logic               m1_gnt_r;
    logic               busy_r;

    // State, guard counter, fairness history and registered grant outputs
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r   <= ST_IDLE;
            guard_r   <= GUARD_ZERO;
            last_m1_r <= 1'b1;
            owner_r   <= OWN_NONE;
            m0_gnt_r  <= 1'b0;
            m1_gnt_r  <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            guard_r   <= guard_s;
            last_m1_r <= last_m1_s;
            m0_gnt_r  <= (state_s == ST_OWN_M0);
            m1_gnt_r  <= (state_s == ST_OWN_M1);
            busy_r    <= (state_s != ST_IDLE);
            case (state_s)
                ST_OWN_M0: owner_r <= OWN_M0;
                ST_OWN_M1: owner_r <= OWN_M1;
                default:   owner_r <= OWN_NONE;
            endcase
        end
    end

    // Next-state logic: grant in IDLE, hold until clean release, then guard
    always_comb begin
        state_s   = state_r;
        guard_s   = guard_r;
        last_m1_s = last_m1_r;
        case (state_r)
            ST_IDLE: begin
                state_s = idle_pick(m0_req_i, m1_req_i, prio_m1_i, last_m1_r);
            end
            ST_OWN_M0: begin
                if (!m0_req_i && m0_cs_ni) begin
                    last_m1_s = 1'b0;
                    if (GUARD_EN) begin
                        state_s = ST_GUARD;
                        guard_s = GUARD_LOAD;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end else begin
                    state_s = ST_OWN_M0;
                end
            end
            ST_OWN_M1: begin
                if (!m1_req_i && m1_cs_ni) begin
                    last_m1_s = 1'b1;
                    if (GUARD_EN) begin
                        state_s = ST_GUARD;
                        guard_s = GUARD_LOAD;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end else begin
                    state_s = ST_OWN_M1;
                end
            end
            ST_GUARD: begin
                if (guard_r == GUARD_ZERO) begin
                    state_s = ST_IDLE;
                end else begin
                    guard_s = guard_r - GUARD_ONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
                guard_s = GUARD_ZERO;
            end
        endcase
    end

    assign m0_gnt_o = m0_gnt_r;
    assign m1_gnt_o = m1_gnt_r;
    assign busy_o   = busy_r;
    assign owner_o  = owner_r;

    qspi_arb_pad_mux u_pad_mux (
        .owner        (owner_r),
        .m0_sclk      (m0_sclk_i),
        .m0_cs_n      (m0_cs_ni),
        .m0_data_out  (m0_data_o_i),
        .m0_oen       (m0_oen_i),
        .m0_data_in   (m0_data_i_o),
        .m1_sclk      (m1_sclk_i),
        .m1_cs_n      (m1_cs_ni),
        .m1_data_out  (m1_data_o_i),
        .m1_oen       (m1_oen_i),
        .m1_data_in   (m1_data_i_o),
        .pad_sclk     (qspi_sclk_o),
        .pad_cs_n     (qspi_cs_no),
        .pad_data_out (qspi_data_o),
        .pad_oen      (qspi_data_oen),
        .pad_data_in  (qspi_data_i)
    );

endmodule

// File: tb/tb_qspi_bus_arbiter.sv
// Directed bench for qspi_bus_arbiter: a GUARD_CYCLES=4 instance and a
// GUARD_CYCLES=0 instance share every input.
module tb_qspi_bus_arbiter;

    logic       clk;
    logic       reset_i;
    logic       prio_m1;
    logic       m0_req, m0_sclk, m0_cs_n;
    logic [3:0] m0_dout, m0_oen;
    logic       m1_req, m1_sclk, m1_cs_n;
    logic [3:0] m1_dout, m1_oen;
    logic [3:0] pad_din;

    logic       m0_gnt, m1_gnt, pad_sclk, pad_cs_n, busy;
    logic [3:0] m0_din, m1_din, pad_dout, pad_oen;
    logic [1:0] owner;

    logic       g0_m0_gnt, g0_m1_gnt, g0_sclk, g0_cs_n, g0_busy;
    logic [3:0] g0_m0_din, g0_m1_din, g0_dout, g0_oen;
    logic [1:0] g0_owner;

    int total = 0;
    int bad   = 0;

    qspi_bus_arbiter #(.GUARD_CYCLES(4), .GUARD_W(3)) dut (
        .clk_i(clk), .reset_i(reset_i), .prio_m1_i(prio_m1),
        .m0_req_i(m0_req), .m0_gnt_o(m0_gnt), .m0_sclk_i(m0_sclk),
        .m0_cs_ni(m0_cs_n), .m0_data_o_i(m0_dout), .m0_oen_i(m0_oen),
        .m0_data_i_o(m0_din),
        .m1_req_i(m1_req), .m1_gnt_o(m1_gnt), .m1_sclk_i(m1_sclk),
        .m1_cs_ni(m1_cs_n), .m1_data_o_i(m1_dout), .m1_oen_i(m1_oen),
        .m1_data_i_o(m1_din),
        .qspi_sclk_o(pad_sclk), .qspi_cs_no(pad_cs_n), .qspi_data_o(pad_dout),
        .qspi_data_oen(pad_oen), .qspi_data_i(pad_din),
        .busy_o(busy), .owner_o(owner)
    );

    qspi_bus_arbiter #(.GUARD_CYCLES(0), .GUARD_W(1)) dut_g0 (
        .clk_i(clk), .reset_i(reset_i), .prio_m1_i(prio_m1),
        .m0_req_i(m0_req), .m0_gnt_o(g0_m0_gnt), .m0_sclk_i(m0_sclk),
        .m0_cs_ni(m0_cs_n), .m0_data_o_i(m0_dout), .m0_oen_i(m0_oen),
        .m0_data_i_o(g0_m0_din),
        .m1_req_i(m1_req), .m1_gnt_o(g0_m1_gnt), .m1_sclk_i(m1_sclk),
        .m1_cs_ni(m1_cs_n), .m1_data_o_i(m1_dout), .m1_oen_i(m1_oen),
        .m1_data_i_o(g0_m1_din),
        .qspi_sclk_o(g0_sclk), .qspi_cs_no(g0_cs_n), .qspi_data_o(g0_dout),
        .qspi_data_oen(g0_oen), .qspi_data_i(pad_din),
        .busy_o(g0_busy), .owner_o(g0_owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value
    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_i = 1'b1; prio_m1 = 1'b0;
        m0_req = 1'b0; m0_sclk = 1'b1; m0_cs_n = 1'b1; m0_dout = 4'hA; m0_oen = 4'h0;
        m1_req = 1'b0; m1_sclk = 1'b1; m1_cs_n = 1'b1; m1_dout = 4'h5; m1_oen = 4'h3;
        pad_din = 4'h6;

        // Reset state: idle pads even though m0 drives non-idle levels
        step(); step();
        reset_i = 1'b0;
        chk("rst_m0_gnt", 8'(m0_gnt), 8'h0);
        chk("rst_m1_gnt", 8'(m1_gnt), 8'h0);
        chk("rst_busy",   8'(busy),   8'h0);
        chk("rst_owner",  8'(owner),  8'h0);
        chk("rst_cs",     8'(pad_cs_n), 8'h1);
        chk("rst_sclk",   8'(pad_sclk), 8'h0);
        chk("rst_oen",    8'(pad_oen),  8'hF);
        chk("rst_dout",   8'(pad_dout), 8'h0);

        // Scenario 1: single request, grant next cycle, pads mirror m0
        m0_req = 1'b1;
        step();
        chk("s1_m0_gnt", 8'(m0_gnt), 8'h1);
        chk("s1_m1_gnt", 8'(m1_gnt), 8'h0);
        chk("s1_owner",  8'(owner),  8'h1);
        chk("s1_busy",   8'(busy),   8'h1);
        m0_cs_n = 1'b0;
        #1;
        chk("s1_sclk",   8'(pad_sclk), 8'h1);
        chk("s1_cs",     8'(pad_cs_n), 8'h0);
        chk("s1_dout",   8'(pad_dout), 8'hA);
        chk("s1_oen",    8'(pad_oen),  8'h0);
        chk("s1_m0_din", 8'(m0_din),   8'h6);
        chk("s1_m1_din", 8'(m1_din),   8'h0);
        m0_sclk = 1'b0; m0_dout = 4'hC;
        #1;
        chk("s1_sclk_tog", 8'(pad_sclk), 8'h0);
        chk("s1_dout_tog", 8'(pad_dout), 8'hC);
        // priority never preempts the owner
        m1_req = 1'b1; prio_m1 = 1'b1;
        step();
        chk("s1_nopre_m0", 8'(m0_gnt), 8'h1);
        chk("s1_nopre_m1", 8'(m1_gnt), 8'h0);
        m1_req = 1'b0; prio_m1 = 1'b0;

        // Scenario 2: req dropped with cs_n low, grant held for 5 cycles
        m0_req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("s2_hold", 8'(m0_gnt), 8'h1);
        end
        m0_cs_n = 1'b1; m0_sclk = 1'b1;
        step();
        chk("s2_rel_gnt",  8'(m0_gnt),   8'h0);
        chk("s2_rel_own",  8'(owner),    8'h0);
        chk("s2_rel_busy", 8'(busy),     8'h1);
        chk("s2_g_cs",     8'(pad_cs_n), 8'h1);
        chk("s2_g_sclk",   8'(pad_sclk), 8'h0);
        chk("s2_g_oen",    8'(pad_oen),  8'hF);
        chk("s2_g_m0din",  8'(m0_din),   8'h0);
        chk("g0_rel_busy", 8'(g0_busy),  8'h0);
        chk("g0_rel_own",  8'(g0_owner), 8'h0);
        // Scenario 5 folded in: m1 requests during the guard interval
        m1_req = 1'b1;
        step();
        chk("g0_m1_gnt",   8'(g0_m1_gnt), 8'h1);
        chk("s5_g2_busy",  8'(busy),   8'h1);
        chk("s5_g2_gnt",   8'(m1_gnt), 8'h0);
        for (int i = 0; i < 2; i++) begin
            step();
            chk("s5_g_busy", 8'(busy),   8'h1);
            chk("s5_g_gnt",  8'(m1_gnt), 8'h0);
        end
        step();
        chk("s5_idle_busy", 8'(busy),   8'h0);
        chk("s5_idle_gnt",  8'(m1_gnt), 8'h0);
        step();
        chk("s5_m1_gnt",  8'(m1_gnt),   8'h1);
        chk("s5_owner",   8'(owner),    8'h2);
        chk("s5_dout",    8'(pad_dout), 8'h5);
        chk("s5_oen",     8'(pad_oen),  8'h3);
        chk("s5_m1_din",  8'(m1_din),   8'h6);
        chk("s5_m0_din",  8'(m0_din),   8'h0);

        // Scenario 3: tie after reset goes to m0, then round robin to m1
        reset_i = 1'b1;
        step();
        reset_i = 1'b0; m0_req = 1'b1; m1_req = 1'b1; prio_m1 = 1'b0;
        step();
        chk("s3_m0_gnt", 8'(m0_gnt), 8'h1);
        chk("s3_m1_gnt", 8'(m1_gnt), 8'h0);
        m0_req = 1'b0;
        step();
        chk("s3_rel", 8'(m0_gnt), 8'h0);
        m0_req = 1'b1;
        for (int i = 0; i < 4; i++) step();
        chk("s3_g_m1", 8'(m1_gnt), 8'h0);
        step();
        chk("s3_rr_m1", 8'(m1_gnt), 8'h1);
        chk("s3_rr_m0", 8'(m0_gnt), 8'h0);

        // Scenario 4: last owner m1 but prio_m1 set -> m1 again
        prio_m1 = 1'b1; m1_req = 1'b0;
        step();
        chk("s4_rel", 8'(m1_gnt), 8'h0);
        m1_req = 1'b1;
        for (int i = 0; i < 5; i++) step();
        chk("s4_m1_gnt", 8'(m1_gnt), 8'h1);
        chk("s4_m0_gnt", 8'(m0_gnt), 8'h0);

        // Scenario 6: reset mid-transaction gives idle pads, no guard
        m1_cs_n = 1'b0;
        #1;
        chk("s6_cs_act", 8'(pad_cs_n), 8'h0);
        reset_i = 1'b1;
        step();
        chk("s6_owner", 8'(owner),    8'h0);
        chk("s6_cs",    8'(pad_cs_n), 8'h1);
        chk("s6_oen",   8'(pad_oen),  8'hF);
        chk("s6_sclk",  8'(pad_sclk), 8'h0);
        chk("s6_busy",  8'(busy),     8'h0);
        chk("s6_gnt",   8'(m1_gnt),   8'h0);
        reset_i = 1'b0;
        step();
        chk("s6_regnt", 8'(m1_gnt), 8'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
